mult_tree_pipe: RTL and testbench

Parametrised, pipelined tree multiplier with valid/ready flow control, per-operation signed/unsigned mode and a transaction tag. It generalises the fixed 32×32 signed tree multiplier into a W×W core with configurable pipeline depth and backpressure. It sits in the datapath between an operand producer (register file or DMA front end) and a result consumer that may stall.

---
 rtl/mult_pkg.sv | 48 ++++
 rtl/mult_booth_pp.sv | 46 ++++
 rtl/mult_tree_pipe.sv | 146 ++++++++++++++
 tb/tb_mult_tree_pipe.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the pipelined Booth/carry-save multiplier:
// Booth digit encoding and tree-shape helper functions.
package mult_pkg;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_M1   = 3'd3,
        BD_M2   = 3'd4
    } booth_digit_e;

    // Radix-4 digit from multiplier bits {b[2i+1], b[2i], b[2i-1]}
    function automatic booth_digit_e booth_enc(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: return BD_P1;
            3'b011:         return BD_P2;
            3'b100:         return BD_M2;
            3'b101, 3'b110: return BD_M1;
            default:        return BD_ZERO;
        endcase
    endfunction

    function automatic int pp_rows(input int width);
        return width / 2 + 1;
    endfunction

    // Rows remaining after applying 'lvls' levels of 3:2 compression to n rows
    function automatic int csa_rows(input int n, input int lvls);
        int r;
        r = n;
        for (int i = 0; i < lvls; i++) r = r - r / 3;
        return r;
    endfunction

    function automatic int csa_levels(input int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = r - r / 3;
            l++;
        end
        return l;
    endfunction

endpackage

// File: rtl/mult_booth_pp.sv
// Radix-4 Booth recoder and partial-product generator for (WIDTH+1)-bit
// sign/zero-extended operands; rows are produced modulo 2^(2*WIDTH).
module mult_booth_pp
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]                          a_i,
    input  logic [WIDTH-1:0]                          b_i,
    input  logic                                      signed_i,
    output logic [pp_rows(WIDTH):0][2*WIDTH-1:0]      rows_o
);

    localparam int PW = 2 * WIDTH;
    localparam int NR = pp_rows(WIDTH);

    logic [PW-1:0]    a_x;
    logic [WIDTH+2:0] b_w;

    assign a_x = {{(PW-WIDTH){signed_i & a_i[WIDTH-1]}}, a_i};
    assign b_w = {{2{signed_i & b_i[WIDTH-1]}}, b_i, 1'b0};

    // Negative digits use one's complement of the row; the missing +1 of
    // each row lands at bit 2i of the last row, where none of them collide.
    always_comb begin
        booth_digit_e  d;
        logic [PW-1:0] m;
        logic          neg;
        rows_o = '0;
        for (int i = 0; i < NR; i++) begin
            d   = booth_enc(b_w[2*i +: 3]);
            m   = '0;
            neg = 1'b0;
            case (d)
                BD_P1:   m = a_x;
                BD_P2:   m = a_x << 1;
                BD_M1:   begin m = a_x;      neg = 1'b1; end
                BD_M2:   begin m = a_x << 1; neg = 1'b1; end
                default: m = '0;
            endcase
            rows_o[i]        = ({PW{neg}} ^ m) << (2 * i);
            rows_o[NR][2*i]  = neg;
        end
    end

endmodule

// File: rtl/mult_tree_pipe.sv
// WxW signed/unsigned tree multiplier: Booth rows, 3:2 carry-save tree spread
// over STAGES registers, final adder; global-stall valid/ready flow control.
module mult_tree_pipe
    import mult_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int PW   = 2 * WIDTH;
    localparam int NPP  = pp_rows(WIDTH) + 1;
    localparam int NLVL = csa_levels(NPP);

    // Last compression level finished by stage s. Stage 1 takes one level,
    // middle stages share the rest, the final stage only does the adder.
    function automatic int lvl_end(input int s);
        if (s <= 0)       return 0;
        if (s >= STAGES)  return NLVL;
        if (STAGES <= 2)  return NLVL;
        return 1 + ((NLVL - 1) * (s - 1) + (STAGES - 3)) / (STAGES - 2);
    endfunction

    logic                   advance;
    logic                   in_fire;
    logic [STAGES:1]        vld_q;
    logic [PW-1:0]          result_d;
    logic [PW-1:0]          result_q;
    logic [TAG_W-1:0]       out_tag_q;
    logic [NPP-1:0][PW-1:0] pp;

    assign advance   = en && !(vld_q[STAGES] && !out_ready);
    assign in_ready  = advance && !reset;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = vld_q[STAGES];
    assign result    = result_q;
    assign out_tag   = out_tag_q;

    mult_booth_pp #(.WIDTH(WIDTH)) u_booth (
        .a_i      (a),
        .b_i      (b),
        .signed_i (in_signed),
        .rows_o   (pp)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else if (advance) begin
            vld_q[1] <= in_fire;
            for (int s = 2; s <= STAGES; s++) vld_q[s] <= vld_q[s-1];
        end
    end

    for (genvar s = 1; s <= STAGES; s++) begin : g_st
        localparam int LO = lvl_end(s - 1);
        localparam int HI = lvl_end(s);
        localparam int NI = csa_rows(NPP, LO);
        localparam int NO = csa_rows(NPP, HI);

        logic [NI-1:0][PW-1:0] rin;
        logic [NO-1:0][PW-1:0] rout;
        logic                  vin;
        logic [TAG_W-1:0]      tin;

        if (s == 1) begin : g_src
            assign rin = pp;
            assign vin = in_fire;
            assign tin = in_tag;
        end else begin : g_src
            assign rin = g_st[s-1].g_reg.rows_q;
            assign vin = vld_q[s-1];
            assign tin = g_st[s-1].g_reg.tag_q;
        end

        for (genvar j = 0; j < HI - LO; j++) begin : g_lv
            localparam int NA = csa_rows(NPP, LO + j);
            localparam int NB = csa_rows(NPP, LO + j + 1);
            logic [NA-1:0][PW-1:0] x;
            logic [NB-1:0][PW-1:0] y;

            if (j == 0) begin : g_in
                assign x = rin;
            end else begin : g_in
                assign x = g_lv[j-1].y;
            end

            // Full adders on groups of three rows; leftover rows pass through
            always_comb begin
                y = '0;
                for (int g = 0; g < NA / 3; g++) begin
                    y[2*g]   = x[3*g] ^ x[3*g+1] ^ x[3*g+2];
                    y[2*g+1] = ((x[3*g] & x[3*g+1]) | (x[3*g] & x[3*g+2]) |
                                (x[3*g+1] & x[3*g+2])) << 1;
                end
                for (int r = 3 * (NA / 3); r < NA; r++) y[r - NA/3] = x[r];
            end
        end

        if (HI == LO) begin : g_rout
            assign rout = rin;
        end else begin : g_rout
            assign rout = g_lv[HI-LO-1].y;
        end

        if (s < STAGES) begin : g_reg
            logic [NO-1:0][PW-1:0] rows_q;
            logic [TAG_W-1:0]      tag_q;

            // Payload only loads behind a valid bit; bubbles leave it untouched
            always_ff @(posedge clk) begin
                if (advance && vin) begin
                    rows_q <= rout;
                    tag_q  <= tin;
                end
            end
        end else begin : g_out
            assign result_d = rout[0] + rout[1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    result_q  <= '0;
                    out_tag_q <= '0;
                end else if (advance && vin) begin
                    result_q  <= result_d;
                    out_tag_q <= tin;
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_tree_pipe.sv
// Randomised and directed checks of mult_tree_pipe against a queue-based
// reference: exact products, tag order, per-op latency, stalls and reset.
module tb_mult_tree_pipe;

    localparam int W  = 32;
    localparam int ST = 3;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            reset, en, in_valid, in_ready, in_signed;
    logic            out_valid, out_ready;
    logic [W-1:0]    a, b;
    logic [TW-1:0]   in_tag, out_tag;
    logic [2*W-1:0]  result;

    always #5 clk = ~clk;

    mult_tree_pipe #(.WIDTH(W), .STAGES(ST), .TAG_W(TW)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .a         (a),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .out_tag   (out_tag)
    );

    typedef struct {
        logic [63:0]   prod;
        logic [TW-1:0] tag;
        int            age;
    } op_t;

    op_t         q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic        armed  = 1'b0;
    logic        chk_zero = 1'b0;
    logic        fired;
    logic [63:0] cur_exp;
    int          sent;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic signed [32:0] xe, ye;
        logic signed [65:0] p;
        xe = {s & x[31], x};
        ye = {s & y[31], y};
        p  = $signed(66'(xe)) * $signed(66'(ye));
        return p[63:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic rand_op(input int n);
        a         = pick();
        b         = pick();
        in_signed = $urandom_range(0, 1) == 1;
        in_tag    = TW'(n);
        cur_exp   = ref_mul(in_signed, a, b);
    endtask

    // One clock: check outputs at the falling edge against the model, then
    // advance the model by what the coming rising edge does.
    task automatic step();
        logic exp_v, adv;
        @(negedge clk);
        exp_v = (q.size() > 0) && (q[0].age == ST);
        adv   = en && !(exp_v && !out_ready);
        fired = 1'b0;
        if (armed) begin
            chk("in_ready", in_ready, !reset && adv);
            chk("out_valid", out_valid, exp_v);
            if (exp_v) begin
                chk("result", result, q[0].prod);
                chk("out_tag", out_tag, q[0].tag);
            end
            if (chk_zero) begin
                chk("rst_result", result, 64'd0);
                chk("rst_tag", out_tag, 64'd0);
                chk_zero = 1'b0;
            end
        end
        if (reset) begin
            q.delete();
            armed    = 1'b1;
            chk_zero = 1'b1;
        end else if (adv) begin
            if (exp_v) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (in_valid) begin
                q.push_back('{prod: cur_exp, tag: in_tag, age: 1});
                fired = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic [3:0] t, input logic [63:0] e);
        a = x; b = y; in_signed = s; in_tag = t; cur_exp = e; in_valid = 1'b1;
        step();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 60 && q.size() > 0; i++) step();
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic        ts [6];
    logic [63:0] te [6];

    initial begin
        ta = '{32'd553524, -32'sd259, -32'sd259, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        tb = '{32'd840, 32'd553524, -32'sd259, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1};
        ts = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        te = '{64'd464960160, -64'sd143362716, 64'd67081,
               64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};

        reset = 1'b1; en = 1'b1; in_valid = 1'b0; in_signed = 1'b0;
        a = '0; b = '0; in_tag = '0; out_ready = 1'b1; cur_exp = '0;
        step(); step();
        reset = 1'b0;
        step();

        // signed basics back-to-back, then the corner products
        for (int i = 0; i < 3; i++) issue(ta[i], tb[i], ts[i], 4'(i + 1), te[i]);
        drain();
        for (int i = 3; i < 6; i++) issue(ta[i], tb[i], ts[i], 4'(i + 1), te[i]);
        drain();

        // backpressure mid-stream
        sent = 0;
        rand_op(sent);
        for (int c = 0; c < 40 && sent < 6; c++) begin
            in_valid  = 1'b1;
            out_ready = !(c >= 3 && c < 7);
            step();
            if (fired) begin sent++; rand_op(sent); end
        end
        out_ready = 1'b1;
        drain();
        chk("bp_sent", 64'(sent), 64'd6);

        // global enable low with two ops in flight
        issue(32'd12345, 32'd678, 1'b0, 4'hA, 64'd8369910);
        issue(-32'sd7, 32'd9, 1'b1, 4'hB, -64'sd63);
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        drain();

        // reset with three ops in flight
        for (int i = 0; i < 3; i++) issue(ta[i], tb[i], ts[i], 4'(i + 8), te[i]);
        reset = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        step();
        issue(32'd3, 32'd5, 1'b0, 4'h5, 64'd15);
        drain();

        // random soak
        sent = 0;
        rand_op(sent);
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            en        = $urandom_range(0, 19) != 0;
            step();
            if (fired) begin sent++; rand_op(sent); end
        end
        en = 1'b1; out_ready = 1'b1;
        drain();
        chk("soak_sent", 64'(sent), 64'd10000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
